// File: rtl/seq_multiplier_18.sv
// Sequential 18x18 unsigned shift-add multiplier.
// One partial product per cycle; 18 RUN cycles per multiply.
module seq_multiplier_18 #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] nhi;
  logic [WIDTH-1:0] nlo;
  logic             last;

  // Ripple-carry adder; carry-out becomes the top bit shifted in.
  always_comb begin
    addend   = lo_q[0] ? mcand_q : '0;
    carry    = '0;
    sum      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = hi_q[i] ^ addend[i] ^ carry[i];
      carry[i+1] = (hi_q[i] & addend[i]) |
                   (carry[i] & (hi_q[i] ^ addend[i]));
    end
  end

  assign nhi  = {carry[WIDTH], sum[WIDTH-1:1]};
  assign nlo  = {sum[0], lo_q[WIDTH-1:1]};
  assign last = (cnt_q == 5'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
        end
      end
      RUN: begin
        hi_d  = nhi;
        lo_d  = nlo;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          done_d = 1'b1;
          ovf_d  = |nhi;
          zero_d = ~|{nhi, nlo};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q == RUN);
    done    = done_q;
    prod_hi = hi_q;
    prod_lo = lo_q;
    ovf     = ovf_q;
    zero    = zero_q;
  end

endmodule

// File: tb/tb_seq_multiplier_18.sv
// Scoreboard bench for seq_multiplier_18: random and directed
// multiplies checked against plain a*b arithmetic.
module tb_seq_multiplier_18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [17:0] a, b;
  logic        busy, done;
  logic [17:0] prod_hi, prod_lo;
  logic        ovf, zero;

  typedef struct {
    logic [35:0] p;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   run    = 0;

  seq_multiplier_18 #(.WIDTH(18)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo),
    .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [17:0] x, y);
    exp_t e;
    e.p    = 36'(x) * 36'(y);
    e.ovf  = (e.p >= 36'd262144);
    e.zero = (e.p == 36'd0);
    return e;
  endfunction

  // Monitor: compares each completion and the busy-window length.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy) run++;
      else if (done) begin
        chk("busy_len", 64'(run), 64'd18);
        run = 0;
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required none");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product", {28'd0, prod_hi, prod_lo}, 64'(e.p));
          chk("ovf", 64'(ovf), 64'(e.ovf));
          chk("zero", 64'(zero), 64'(e.zero));
        end
      end else run = 0;
    end else run = 0;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 100) begin
      step(1);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles", busy, t);
    end
  endtask

  task automatic issue(input logic [17:0] x, y);
    wait_idle();
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    step(1);
    start = 1'b0;
  endtask

  // Scrambles inputs and pokes start while busy; result must not move.
  task automatic run_one(input logic [17:0] x, y, input bit noisy);
    exp_t e;
    issue(x, y);
    while (busy) begin
      if (noisy) begin
        a     = 18'($urandom);
        b     = 18'($urandom);
        start = 1'($urandom);
      end
      step(1);
    end
    start = 1'b0;
    step(3);
    e = model(x, y);
    chk("hold_prod", {28'd0, prod_hi, prod_lo}, 64'(e.p));
    chk("hold_flags", {62'd0, ovf, zero}, {62'd0, e.ovf, e.zero});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    a     = 18'h3FFFF;
    b     = 18'h3FFFF;
    step(3);
    chk("rst_outs", {44'd0, busy, done, prod_hi, prod_lo, ovf, zero}, 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    step(1);
    chk("rst_idle", {62'd0, busy, done}, 64'd0);

    run_one(18'd3, 18'd5, 1'b0);
    run_one(18'h3FFFF, 18'h3FFFF, 1'b1);
    run_one(18'd512, 18'd512, 1'b0);
    run_one(18'd0, 18'h01234, 1'b1);
    run_one(18'h3FFFF, 18'd1, 1'b0);
    run_one(18'd1, 18'h20000, 1'b0);

    // Re-start at E5 with other operands is ignored.
    issue(18'd7, 18'd9);
    step(4);
    a     = 18'd1;
    b     = 18'd1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle();
    step(2);
    chk("restart_ign", 64'(prod_lo), 64'd63);

    // Reset at E7 aborts with no done.
    issue(18'd100, 18'd200);
    step(6);
    rst_n = 1'b0;
    exp_q.delete();
    step(1);
    chk("abort_outs", {44'd0, busy, done, prod_hi, prod_lo, ovf, zero}, 64'd0);
    step(2);
    chk("abort_nodone", 64'(done), 64'd0);
    rst_n = 1'b1;
    step(1);
    run_one(18'd100, 18'd200, 1'b0);
    chk("after_rst", 64'(prod_lo), 64'd20000);

    // start held high: one accept every 19 cycles.
    wait_idle();
    step(2);
    done_cyc.delete();
    a     = 18'd2;
    b     = 18'd3;
    start = 1'b1;
    repeat (3) exp_q.push_back(model(18'd2, 18'd3));
    step(57);
    start = 1'b0;
    step(25);
    chk("b2b_count", 64'(done_cyc.size()), 64'd3);
    if (done_cyc.size() == 3) begin
      chk("b2b_gap1", 64'(done_cyc[1] - done_cyc[0]), 64'd19);
      chk("b2b_gap2", 64'(done_cyc[2] - done_cyc[1]), 64'd19);
    end

    for (int i = 0; i < 40; i++) begin
      logic [17:0] x, y;
      x = 18'($urandom);
      y = 18'($urandom);
      if (i % 8 == 0) x = 18'($urandom_range(0, 3));
      if (i % 8 == 1) y = 18'($urandom_range(0, 3));
      run_one(x, y, i[0]);
    end

    wait_idle();
    step(25);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
